// File: rtl/alu_result_fifo.sv
// Result FIFO behind the 4-bit functional units: tags each result with its opcode and status flags.
// Optional status ports (count, drop_sticky, drop_clr) are enabled by ALU_RESULT_FIFO_STATUS_EN.
module alu_result_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [OPW-1:0]   out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_parity,
`ifdef ALU_RESULT_FIFO_STATUS_EN
  output logic [$clog2(DEPTH):0] count,
  output logic             drop_sticky,
  input  logic             drop_clr,
`endif
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [OPW-1:0]   op;
    logic             zero;
    logic             neg;
    logic             parity;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          alive;
  logic          push;
  logic          pop;

  // Full when pointers match in the index bits but differ in the wrap bit.
  assign full     = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = alive & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = ~empty & out_ready;

  // Flags are frozen at capture so the consumer sees what the ALU produced.
  always_comb begin
    wr_entry        = '0;
    wr_entry.result = in_result;
    wr_entry.op     = in_op;
    wr_entry.zero   = (in_result == '0);
    wr_entry.neg    = in_result[WIDTH-1];
    wr_entry.parity = ^in_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      alive <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  // First-word fall-through head, zeroed while nothing is stored.
  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_valid  = ~empty;
  assign out_result = empty ? '0 : head.result;
  assign out_op     = empty ? '0 : head.op;
  assign out_zero   = ~empty & head.zero;
  assign out_neg    = ~empty & head.neg;
  assign out_parity = ~empty & head.parity;

`ifdef ALU_RESULT_FIFO_STATUS_EN
  assign count = wr_ptr - rd_ptr;

  // A drop in the same cycle as a clear keeps the sticky bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_sticky <= 1'b0;
    end else if (in_valid & ~in_ready) begin
      drop_sticky <= 1'b1;
    end else if (drop_clr) begin
      drop_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed plan steps plus random traffic against a queue model.
// Status-port checks are included when ALU_RESULT_FIFO_STATUS_EN is defined.
module tb_alu_result_fifo;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] in_result = 4'h0;
  logic [2:0] in_op = 3'd0;
  logic       in_ready, out_valid, out_zero, out_neg, out_parity, full, empty;
  logic [3:0] out_result;
  logic [2:0] out_op;
`ifdef ALU_RESULT_FIFO_STATUS_EN
  logic [2:0] count;
  logic       drop_sticky;
  logic       drop_clr = 1'b0;
  bit         m_sticky = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] r;
    logic [2:0] o;
  } ent_t;
  ent_t q[$];
  bit   m_alive = 1'b0;

  alu_result_fifo #(.WIDTH(4), .DEPTH(D), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
    .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity),
`ifdef ALU_RESULT_FIFO_STATUS_EN
    .count(count), .drop_sticky(drop_sticky), .drop_clr(drop_clr),
`endif
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the queue model.
  task automatic check_all(input string tag);
    logic [3:0] er;
    logic [2:0] eo;
    int         n;
    n  = q.size();
    er = (n > 0) ? q[0].r : 4'h0;
    eo = (n > 0) ? q[0].o : 3'd0;
    chk({tag, ".valid"}, 32'(out_valid), 32'(n > 0));
    chk({tag, ".result"}, 32'(out_result), 32'(er));
    chk({tag, ".op"}, 32'(out_op), 32'(eo));
    chk({tag, ".zero"}, 32'(out_zero), 32'((n > 0) && (er == 0)));
    chk({tag, ".neg"}, 32'(out_neg), 32'((n > 0) && (er >= 8)));
    chk({tag, ".parity"}, 32'(out_parity), 32'((n > 0) && ($countones(er) % 2 == 1)));
    chk({tag, ".full"}, 32'(full), 32'(n == D));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_alive && n < D));
`ifdef ALU_RESULT_FIFO_STATUS_EN
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".sticky"}, 32'(drop_sticky), 32'(m_sticky));
`endif
  endtask

  // One clock: predict transfer from the model, advance, then check.
  task automatic cyc(input string tag);
    bit   p, pp;
    ent_t e;
    p  = in_valid && m_alive && q.size() < D;
    pp = out_ready && q.size() > 0;
    e.r = in_result;
    e.o = in_op;
`ifdef ALU_RESULT_FIFO_STATUS_EN
    if (in_valid && !p) m_sticky = 1'b1;
    else if (drop_clr) m_sticky = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (pp) void'(q.pop_front());
    if (p) q.push_back(e);
    m_alive = 1'b1;
    check_all(tag);
  endtask

  task automatic push_val(input logic [3:0] r, input logic [2:0] o, input string tag);
    in_valid = 1'b1; in_result = r; in_op = o;
    cyc(tag);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] fill_v [4];
    logic       par_v [4];
    fill_v[0] = 4'h0; fill_v[1] = 4'h5; fill_v[2] = 4'hF; fill_v[3] = 4'h8;
    par_v[0] = 1'b0; par_v[1] = 1'b0; par_v[2] = 1'b0; par_v[3] = 1'b1;

    // Reset held for 3 cycles, then idle.
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset");
    #2 rst_n = 1'b1;
    cyc("idle");
    chk("idle.in_ready_const", 32'(in_ready), 32'd1);

    // Single push held while the consumer stalls.
    push_val(4'hA, 3'd1, "single");
    chk("single.result_const", 32'(out_result), 32'hA);
    chk("single.neg_const", 32'(out_neg), 32'd1);
    chk("single.parity_const", 32'(out_parity), 32'd0);
    cyc("hold0");
    cyc("hold1");
    out_ready = 1'b1;
    cyc("single_pop");
    out_ready = 1'b0;

    // Fill, overflow attempt, drain.
    for (int i = 0; i < 4; i++) push_val(fill_v[i], 3'(i), "fill");
    chk("fill.full_const", 32'(full), 32'd1);
    chk("fill.in_ready_const", 32'(in_ready), 32'd0);
    push_val(4'h3, 3'd7, "overflow");
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain.result_const", 32'(out_result), 32'(fill_v[i]));
      chk("drain.parity_const", 32'(out_parity), 32'(par_v[i]));
      if (i == 0) chk("drain.zero_const", 32'(out_zero), 32'd1);
      cyc("drain");
    end
    out_ready = 1'b0;

    // Refill across the pointer wrap with interleaved pops.
    for (int i = 0; i < 6; i++) begin
      out_ready = (i % 2 == 1);
      push_val(4'(i + 9), 3'(i), "wrap");
    end
    out_ready = 1'b1;
    repeat (6) cyc("wrap_drain");
    out_ready = 1'b0;

    // Steady push+pop with two entries resident.
    push_val(4'h1, 3'd2, "pp_pre");
    push_val(4'h2, 3'd3, "pp_pre");
    in_valid = 1'b1; in_result = 4'h7; in_op = 3'd4; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_op = 3'(i);
      cyc("push_pop");
    end
    in_valid = 1'b0;
    repeat (3) cyc("pp_drain");
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) push_val(4'(i + 4), 3'(i), "pre_rst");
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_alive = 1'b0;
`ifdef ALU_RESULT_FIFO_STATUS_EN
    m_sticky = 1'b0;
`endif
    check_all("async_rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc("post_rst");
    push_val(4'h2, 3'd5, "post_rst_push");
    chk("post_rst.head_const", 32'(out_result), 32'h2);
    out_ready = 1'b1;
    cyc("post_rst_pop");
    out_ready = 1'b0;

`ifdef ALU_RESULT_FIFO_STATUS_EN
    for (int i = 0; i < 4; i++) push_val(4'(i), 3'(i), "st_fill");
    push_val(4'hC, 3'd1, "st_drop");
    chk("st_drop.sticky_const", 32'(drop_sticky), 32'd1);
    chk("st_drop.count_const", 32'(count), 32'd4);
    drop_clr = 1'b1;
    cyc("st_clr");
    chk("st_clr.sticky_const", 32'(drop_sticky), 32'd0);
    in_valid = 1'b1;
    cyc("st_clr_drop");
    chk("st_clr_drop.sticky_const", 32'(drop_sticky), 32'd1);
    in_valid = 1'b0; drop_clr = 1'b0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_result = 4'($urandom);
      in_op     = 3'($urandom);
`ifdef ALU_RESULT_FIFO_STATUS_EN
      drop_clr  = ($urandom_range(0, 7) == 0);
`endif
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 4-bit functional units (negation, add, logic ops).
- Captures each unit result together with its opcode tag and computes status flags at capture time.
- Buffers the entries in a small FIFO and presents them to the consumer (display/output register) over a valid/ready handshake.
- Decouples single-cycle ALU results from a consumer that can stall.

Parameters:
- WIDTH, 4, result data width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- OPW, 3, opcode tag width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  FIFO can accept an entry.
- in_result  input  WIDTH  result from the functional unit.
- in_op  input  OPW  opcode that produced the result.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_result  output  WIDTH  head result.
- out_op  output  OPW  head opcode.
- out_zero  output  1  head result == 0.
- out_neg  output  1  head result MSB.
- out_parity  output  1  XOR of head result bits; 1 = odd number of ones.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.

Behaviour:
- Reset, asynchronous, active while rst_n = 0:
  - Pointers and occupancy are cleared.
  - Outputs: in_ready = 0 while in reset, 1 after release; out_valid = 0; out_result / out_op / flags = 0; full = 0; empty = 1.
- Reset asserted mid-operation discards all stored entries immediately. No partial transfer survives.
- Push: in_valid & in_ready at a rising edge writes {in_result, in_op, zero, neg, parity} at the write pointer, then write pointer +1.
- Flags are computed from in_result at push time and stored; they are not recomputed at read.
- Pop: out_valid & out_ready at a rising edge advances the read pointer +1.
- Pointers wrap modulo DEPTH. Occupancy is tracked with one extra pointer bit: full when the pointers differ only in the MSB.
- in_ready = !full, combinational from registered state. There is no pass-through when full, even if out_ready = 1.
- out_valid = !empty. Head fields are read combinationally from storage at the read pointer (first-word fall-through).
- All out_* data fields are forced to 0 when empty.
- Latency: an entry pushed at edge N is visible at out_* after edge N, i.e. 1 cycle; there is no empty-bypass path.
- Simultaneous push and pop:
  - Both occur when not full and not empty; occupancy is unchanged.
  - When empty, only the push occurs.
  - When full, only the pop occurs, because in_ready = 0.
- in_valid while in_ready = 0: the input is ignored and nothing is written. Upstream must hold the value.
- Head fields must stay stable while out_valid & !out_ready.
- Ordering is strictly FIFO; no entry may be lost or duplicated.

Optional Feature:
- Macro: ALU_RESULT_FIFO_STATUS_EN.
- Defined, extra ports are added:
  - count (output, log2(DEPTH)+1 bits): current occupancy, reset 0.
  - drop_sticky (output, 1 bit): set on any cycle with in_valid & !in_ready; reset 0; stays set until cleared.
  - drop_clr (input, 1 bit): synchronous clear of drop_sticky. If a drop and drop_clr occur in the same cycle, set wins.
- Not defined: these ports and their logic are absent. Core behaviour is identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high -> out_valid=0, empty=1, full=0, in_ready=1, out_result=0.
- Single push: in_result=4'hA, in_op=3'd1, out_ready=0 -> next cycle out_valid=1, out_result=4'hA, out_zero=0, out_neg=1, out_parity=0; values held while out_ready=0.
- Fill and wrap:
  - Push 4'h0, 4'h5, 4'hF, 4'h8 with out_ready=0 -> full=1, in_ready=0; a 5th push of 4'h3 is ignored.
  - Then drain -> order 0,5,F,8; first entry out_zero=1; parities 0,0,0,1.
  - Refill past the pointer wrap -> ordering still correct.
- Simultaneous push and pop: 2 entries held; push 4'h7 and pop in the same cycle for 6 cycles -> occupancy stays 2, output sequence in exact push order.
- Reset mid-operation: 3 entries stored, rst_n pulsed low mid-cycle -> out_valid drops to 0 asynchronously and empty=1; after release the next push 4'h2 appears as the head.
- With ALU_RESULT_FIFO_STATUS_EN:
  - Push while full -> drop_sticky=1 and count=4.
  - drop_clr pulse with no drop -> drop_sticky=0.
  - drop_clr together with a new drop -> drop_sticky stays 1.
